// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, data width and bit-timing helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    function automatic int ticks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input line.
// Reset value is parameterised so an idle-high line resets to idle.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RESET_VAL;
            q  <= RESET_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and framing-error strobe.
// Define UART_RX_PARITY_EN to add an even-parity bit and o_parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int ClockFrequency = 50_000_000,
    parameter int BaudRate       = 2_340_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_data,
    output logic [7:0] o_frame,
    output logic       o_valid,
    output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    output logic       o_busy
);

    localparam int TicksPerBit = ticks_per_bit(ClockFrequency, BaudRate);
    localparam int HalfBit     = TicksPerBit / 2;
    localparam int TW          = $clog2(TicksPerBit);
`ifdef UART_RX_PARITY_EN
    localparam int BW          = 4;
`else
    localparam int BW          = 3;
`endif

    logic          rxs;
    state_t        state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [7:0]    shreg, sh_n;
    logic [7:0]    frame_n;
    logic          valid_n, ferr_n;
    logic          tick_end, half_end;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_n, perr_n;
`endif

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (CLK),
        .rst_n (RST),
        .d     (i_data),
        .q     (rxs)
    );

    assign tick_end = (tick == TW'(TicksPerBit - 1));
    assign half_end = (tick == TW'(HalfBit - 1));
    assign o_busy   = (state != IDLE);

    // State, counters and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= WAIT_IDLE;
            tick        <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            o_frame     <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            tick        <= tick_n;
            bit_cnt     <= bit_n;
            shreg       <= sh_n;
            o_frame     <= frame_n;
            o_valid     <= valid_n;
            o_frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_n;
            o_parity_err <= perr_n;
`endif
        end
    end

    // Next-state, sampling and strobe decisions
    always_comb begin
        state_n = state;
        tick_n  = tick;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        frame_n = o_frame;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par_q;
        perr_n  = 1'b0;
`endif
        unique case (state)
            WAIT_IDLE: begin
                if (rxs) state_n = IDLE;
            end
            IDLE: begin
                if (!rxs) begin
                    state_n = START;
                    tick_n  = '0;
                    bit_n   = '0;
                end
            end
            START: begin
                if (half_end) begin
                    tick_n  = '0;
                    state_n = rxs ? IDLE : DATA;
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            DATA: begin
                if (tick_end) begin
                    tick_n = '0;
                    sh_n   = {rxs, shreg[7:1]};
                    bit_n  = bit_cnt + 1'b1;
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_end) begin
                    tick_n  = '0;
                    par_n   = rxs;
                    state_n = STOP;
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick_end) begin
                    tick_n = '0;
`ifdef UART_RX_PARITY_EN
                    perr_n = (par_q != ^shreg);
`endif
                    if (rxs) begin
                        state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_q == ^shreg) begin
                            frame_n = shreg;
                            valid_n = 1'b1;
                        end
`else
                        frame_n = shreg;
                        valid_n = 1'b1;
`endif
                    end else begin
                        // Line held low: wait for idle before rearming
                        ferr_n  = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            default: state_n = WAIT_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with a frame-level reference model.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx;

    localparam int T = 50_000_000 / 2_340_000;
    localparam int H = T / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    // start driven at cycle k; 2 sync flops + detect edge, then mid-bit
    localparam int LAT = 3 + H + NB * T;
    localparam int FLEN = (NB + 1) * T;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       i_data = 1'b1;
    logic [7:0] o_frame;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit both_seen = 1'b0;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] d;
    } ev_t;
    ev_t evq[$];

    uart_rx dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_data      (i_data),
        .o_frame     (o_frame),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(o_parity_err),
`endif
        .o_busy      (o_busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (o_valid) evq.push_back('{cyc, 0, o_frame});
        if (o_frame_err) evq.push_back('{cyc, 1, o_frame});
`ifdef UART_RX_PARITY_EN
        if (o_parity_err) evq.push_back('{cyc, 2, o_frame});
`endif
        if (o_valid && o_frame_err) both_seen = 1'b1;
    end

    task automatic hold(input logic b, input int n);
        @(posedge CLK);
        #1 i_data = b;
        repeat (n - 1) @(posedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic pflip, output int k);
        @(posedge CLK);
        #1 i_data = 1'b0;
        k = cyc;
        repeat (T - 1) @(posedge CLK);
        for (int i = 0; i < 8; i++) hold(d[i], T);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ pflip, T);
`endif
        hold(stop, T);
    endtask

    task automatic test_reset;
        RST = 1'b0;
        i_data = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        tests++;
        if (o_frame !== 8'h00 || o_valid !== 1'b0 || o_frame_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: frame=%h valid=%b ferr=%b want 00/0/0",
                     o_frame, o_valid, o_frame_err);
        end
        tests++;
        if (o_busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_busy: got %b want 1", o_busy);
        end
        RST = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        tests++;
        if (o_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b want 0", o_busy);
        end
    endtask

    task automatic test_single;
        int k;
        evq.delete();
        send_frame(8'h55, 1'b1, 1'b0, k);
        hold(1'b1, T);
        tests++;
        if (evq.size() != 1) begin
            fails++;
            $display("FAIL single_count: got %0d strobes want 1", evq.size());
        end else begin
            tests++;
            if (evq[0].kind != 0 || evq[0].d !== 8'h55) begin
                fails++;
                $display("FAIL single_data: kind=%0d frame=%h want 0/55",
                         evq[0].kind, evq[0].d);
            end
            tests++;
            if (evq[0].cyc != k + LAT) begin
                fails++;
                $display("FAIL single_time: at %0d want %0d", evq[0].cyc, k + LAT);
            end
        end
        tests++;
        if (o_frame !== 8'h55) begin
            fails++;
            $display("FAIL single_hold: frame=%h want 55", o_frame);
        end
    endtask

    task automatic test_back_to_back;
        int k0, k1;
        evq.delete();
        send_frame(8'h00, 1'b1, 1'b0, k0);
        send_frame(8'hFF, 1'b1, 1'b0, k1);
        hold(1'b1, T);
        tests++;
        if (evq.size() != 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d strobes want 2", evq.size());
        end else begin
            tests++;
            if (evq[0].d !== 8'h00 || evq[1].d !== 8'hFF ||
                evq[0].kind != 0 || evq[1].kind != 0) begin
                fails++;
                $display("FAIL b2b_data: got %h,%h want 00,FF", evq[0].d, evq[1].d);
            end
            tests++;
            if (evq[1].cyc - evq[0].cyc != FLEN || evq[0].cyc != k0 + LAT) begin
                fails++;
                $display("FAIL b2b_time: gap %0d want %0d", evq[1].cyc - evq[0].cyc, FLEN);
            end
        end
    endtask

    task automatic test_glitch;
        bit dropped = 1'b0;
        evq.delete();
        hold(1'b0, 5);
        @(posedge CLK);
        #1 i_data = 1'b1;
        for (int i = 0; i < H + 3; i++) begin
            @(posedge CLK);
            #1;
            if (!o_busy) begin
                dropped = 1'b1;
                break;
            end
        end
        tests++;
        if (!dropped) begin
            fails++;
            $display("FAIL glitch_busy: busy=%b want 0 within %0d cycles", o_busy, H + 3);
        end
        hold(1'b1, 12 * T);
        tests++;
        if (evq.size() != 0) begin
            fails++;
            $display("FAIL glitch_strobe: got %0d strobes want 0", evq.size());
        end
    endtask

    task automatic test_frame_err;
        int k;
        bit low_idle = 1'b0;
        logic [7:0] prev;
        prev = o_frame;
        evq.delete();
        send_frame(8'hA5, 1'b0, 1'b0, k);
        for (int i = 0; i < 50; i++) begin
            @(posedge CLK);
            #1;
            if (!o_busy) low_idle = 1'b1;
        end
        tests++;
        if (low_idle) begin
            fails++;
            $display("FAIL ferr_busy: busy dropped while line low, want 1");
        end
        hold(1'b1, T);
        tests++;
        if (evq.size() != 1 || evq[0].kind != 1 || evq[0].cyc != k + LAT) begin
            fails++;
            $display("FAIL ferr_pulse: got %0d events want 1 err at %0d",
                     evq.size(), k + LAT);
        end else begin
            tests++;
            if (evq[0].d !== prev) begin
                fails++;
                $display("FAIL ferr_frame: frame=%h want %h", evq[0].d, prev);
            end
        end
        evq.delete();
        send_frame(8'h3C, 1'b1, 1'b0, k);
        hold(1'b1, T);
        tests++;
        if (evq.size() != 1 || evq[0].kind != 0 || evq[0].d !== 8'h3C) begin
            fails++;
            $display("FAIL ferr_recover: got %0d events frame=%h want 1 valid 3C",
                     evq.size(), o_frame);
        end
    endtask

    task automatic test_reset_mid;
        int k;
        evq.delete();
        hold(1'b0, 4 * T + H);
        #1 RST = 1'b0;
        #1;
        tests++;
        if (o_frame !== 8'h00 || o_valid !== 1'b0 ||
            o_frame_err !== 1'b0 || o_busy !== 1'b1) begin
            fails++;
            $display("FAIL midrst_outputs: frame=%h v=%b e=%b busy=%b want 00/0/0/1",
                     o_frame, o_valid, o_frame_err, o_busy);
        end
        repeat (4) @(posedge CLK);
        #1 RST = 1'b1;
        hold(1'b1, 12 * T);
        tests++;
        if (evq.size() != 0) begin
            fails++;
            $display("FAIL midrst_strobe: got %0d strobes want 0", evq.size());
        end
        send_frame(8'h81, 1'b1, 1'b0, k);
        hold(1'b1, T);
        tests++;
        if (evq.size() != 1 || evq[0].kind != 0 || evq[0].d !== 8'h81 ||
            evq[0].cyc != k + LAT) begin
            fails++;
            $display("FAIL midrst_recover: got %0d events frame=%h want valid 81",
                     evq.size(), o_frame);
        end
    endtask

    task automatic test_random;
        ev_t exp_q[$];
        logic [7:0] last_good;
        logic [7:0] d;
        logic stop;
        int k, g;
        last_good = o_frame;
        evq.delete();
        for (int n = 0; n < 12; n++) begin
            d = 8'($urandom);
            stop = ($urandom_range(3, 0) != 0);
            send_frame(d, stop, 1'b0, k);
            if (stop) begin
                last_good = d;
                exp_q.push_back('{k + LAT, 0, d});
                g = $urandom_range(T, 0);
            end else begin
                exp_q.push_back('{k + LAT, 1, last_good});
                g = $urandom_range(T, 2);
            end
            if (g > 0) hold(1'b1, g);
        end
        hold(1'b1, T);
        tests++;
        if (evq.size() != exp_q.size()) begin
            fails++;
            $display("FAIL rand_count: got %0d events want %0d", evq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (evq[i].kind != exp_q[i].kind || evq[i].d !== exp_q[i].d ||
                    evq[i].cyc != exp_q[i].cyc) begin
                    fails++;
                    $display("FAIL rand_%0d: kind=%0d d=%h t=%0d want %0d/%h/%0d", i,
                             evq[i].kind, evq[i].d, evq[i].cyc,
                             exp_q[i].kind, exp_q[i].d, exp_q[i].cyc);
                end
            end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int k;
        logic [7:0] prev;
        prev = o_frame;
        evq.delete();
        send_frame(8'h55, 1'b1, 1'b1, k);
        hold(1'b1, T);
        tests++;
        if (evq.size() != 1 || evq[0].kind != 2 || evq[0].d !== prev) begin
            fails++;
            $display("FAIL parity_bad: got %0d events frame=%h want 1 parity err, %h",
                     evq.size(), o_frame, prev);
        end
        evq.delete();
        send_frame(8'h55, 1'b1, 1'b0, k);
        hold(1'b1, T);
        tests++;
        if (evq.size() != 1 || evq[0].kind != 0 || evq[0].d !== 8'h55) begin
            fails++;
            $display("FAIL parity_good: got %0d events frame=%h want valid 55",
                     evq.size(), o_frame);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        tests++;
        if (both_seen) begin
            fails++;
            $display("FAIL exclusive: valid and frame_err high together, want never");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
